// File: rtl/serial_frame_tx_if.sv
// Handshake and serial-line bundle for serial_frame_tx.
// The producer drives in_data/in_valid; the transmitter drives the rest.
interface serial_frame_tx_if #(
  parameter int DATA_W = 8
);
  logic [DATA_W-1:0] in_data;
  logic              in_valid;
  logic              in_ready;
  logic              tx;
  logic              busy;
  logic              done;

  modport master (
    output in_data,
    output in_valid,
    input  in_ready,
    input  tx,
    input  busy,
    input  done
  );

  modport slave (
    input  in_data,
    input  in_valid,
    output in_ready,
    output tx,
    output busy,
    output done
  );
endinterface

// File: rtl/serial_frame_tx.sv
// Serial frame transmitter: start bit, DATA_W data bits LSB first,
// optional even parity bit, stop bit. Each bit lasts CLKS_PER_BIT cycles.
// All outputs come straight from flops so the line never glitches.
module serial_frame_tx #(
  parameter int DATA_W       = 8,
  parameter int CLKS_PER_BIT = 4,
  parameter int PARITY_EN    = 1
) (
  input  logic             clk,
  input  logic             reset,
  serial_frame_tx_if.slave bus
);

  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int IDX_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] START  = 3'd1;
  localparam logic [2:0] DATA   = 3'd2;
  localparam logic [2:0] PARITY = 3'd3;
  localparam logic [2:0] STOP   = 3'd4;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_W - 1);

  // Even parity: the parity bit makes the total count of ones even.
  function automatic logic even_parity(input logic [DATA_W-1:0] d);
    return ^d;
  endfunction

  logic [2:0]        r_state;
  logic [CNT_W-1:0]  r_cnt;
  logic [IDX_W-1:0]  r_idx;
  logic [DATA_W-1:0] r_shift;
  logic              r_par;
  logic              r_tx;
  logic              r_busy;
  logic              r_ready;
  logic              r_done;

  logic              w_bit_end;
  logic              w_accept;
  logic [DATA_W-1:0] w_shift_nxt;

  assign w_bit_end   = (r_cnt == CNT_LAST);
  assign w_accept    = bus.in_valid && (r_state == IDLE);
  assign w_shift_nxt = r_shift >> 1;

  // Frame sequencer: state, bit timing, data shifting and registered outputs.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_idx   <= '0;
      r_shift <= '0;
      r_par   <= 1'b0;
      r_tx    <= 1'b1;
      r_busy  <= 1'b0;
      r_ready <= 1'b1;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            // Capture the word and drive the start bit on the very next cycle.
            r_shift <= bus.in_data;
            r_par   <= even_parity(bus.in_data);
            r_cnt   <= '0;
            r_idx   <= '0;
            r_tx    <= 1'b0;
            r_busy  <= 1'b1;
            r_ready <= 1'b0;
            r_state <= START;
          end else begin
            r_tx <= 1'b1;
          end
        end

        START: begin
          if (w_bit_end) begin
            r_cnt   <= '0;
            r_idx   <= '0;
            r_tx    <= r_shift[0];
            r_state <= DATA;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end

        DATA: begin
          if (w_bit_end) begin
            r_cnt <= '0;
            if (r_idx == IDX_LAST) begin
              if (PARITY_EN != 0) begin
                r_tx    <= r_par;
                r_state <= PARITY;
              end else begin
                r_tx    <= 1'b1;
                r_state <= STOP;
              end
            end else begin
              // Shift the next data bit down to bit 0 and put it on the line.
              r_idx   <= r_idx + IDX_W'(1);
              r_shift <= w_shift_nxt;
              r_tx    <= w_shift_nxt[0];
            end
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end

        PARITY: begin
          if (w_bit_end) begin
            r_cnt   <= '0;
            r_tx    <= 1'b1;
            r_state <= STOP;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end

        STOP: begin
          if (w_bit_end) begin
            // Back in IDLE next cycle: pulse done and reopen the input.
            r_cnt   <= '0;
            r_tx    <= 1'b1;
            r_busy  <= 1'b0;
            r_ready <= 1'b1;
            r_done  <= 1'b1;
            r_state <= IDLE;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end

        default: begin
          r_state <= IDLE;
          r_cnt   <= '0;
          r_idx   <= '0;
          r_tx    <= 1'b1;
          r_busy  <= 1'b0;
          r_ready <= 1'b1;
        end
      endcase
    end
  end

  assign bus.tx       = r_tx;
  assign bus.busy     = r_busy;
  assign bus.in_ready = r_ready;
  assign bus.done     = r_done;

endmodule

// File: tb/tb_serial_frame_tx.sv
// Directed bench for serial_frame_tx: three builds (default, no parity,
// 1-bit/2-clock) sharing one clock and reset, checked cycle by cycle.
module tb_serial_frame_tx;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_err;

  serial_frame_tx_if #(.DATA_W(8)) if0 ();
  serial_frame_tx_if #(.DATA_W(8)) if1 ();
  serial_frame_tx_if #(.DATA_W(1)) if2 ();

  serial_frame_tx u0 (
    .clk   (clk),
    .reset (reset),
    .bus   (if0)
  );

  serial_frame_tx #(.PARITY_EN(0)) u1 (
    .clk   (clk),
    .reset (reset),
    .bus   (if1)
  );

  serial_frame_tx #(.DATA_W(1), .CLKS_PER_BIT(2)) u2 (
    .clk   (clk),
    .reset (reset),
    .bus   (if2)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int sel, input logic [7:0] d, input logic v);
    case (sel)
      0: begin if0.in_data = d;    if0.in_valid = v; end
      1: begin if1.in_data = d;    if1.in_valid = v; end
      2: begin if2.in_data = d[0]; if2.in_valid = v; end
      default: ;
    endcase
  endtask

  // {tx, busy, done, in_ready}
  function automatic logic [3:0] outs(input int sel);
    case (sel)
      0:       return {if0.tx, if0.busy, if0.done, if0.in_ready};
      1:       return {if1.tx, if1.busy, if1.done, if1.in_ready};
      2:       return {if2.tx, if2.busy, if2.done, if2.in_ready};
      default: return 4'h0;
    endcase
  endfunction

  // Called at the first cycle after acceptance. frame[k] is the k-th bit on
  // the line (start first). Ends at the done cycle, without stepping past it.
  task automatic check_frame(input int sel, input string tag, input logic [15:0] frame,
                             input int nb, input int cpb, input bit scramble);
    logic [3:0] o;
    for (int c = 1; c <= nb * cpb; c++) begin
      o = outs(sel);
      chk({tag, "_tx"},    {31'd0, o[3]}, {31'd0, frame[(c - 1) / cpb]});
      chk({tag, "_busy"},  {31'd0, o[2]}, 32'd1);
      chk({tag, "_done"},  {31'd0, o[1]}, 32'd0);
      chk({tag, "_ready"}, {31'd0, o[0]}, 32'd0);
      if (scramble) drive(sel, 8'($urandom), 1'($urandom));
      step();
    end
    o = outs(sel);
    chk({tag, "_end_tx"},    {31'd0, o[3]}, 32'd1);
    chk({tag, "_end_busy"},  {31'd0, o[2]}, 32'd0);
    chk({tag, "_end_done"},  {31'd0, o[1]}, 32'd1);
    chk({tag, "_end_ready"}, {31'd0, o[0]}, 32'd1);
  endtask

  task automatic send(input int sel, input logic [7:0] d);
    drive(sel, d, 1'b1);
    step();
    drive(sel, 8'h00, 1'b0);
  endtask

  task automatic after_done(input int sel, input string tag);
    logic [3:0] o;
    drive(sel, 8'h00, 1'b0);
    step();
    o = outs(sel);
    chk({tag, "_done_clr"}, {31'd0, o[1]}, 32'd0);
    chk({tag, "_idle_tx"},  {31'd0, o[3]}, 32'd1);
  endtask

  initial begin
    logic [3:0] o;
    n_checks = 0;
    n_err    = 0;
    reset    = 1'b0;
    drive(0, 8'h33, 1'b1);
    drive(1, 8'h00, 1'b0);
    drive(2, 8'h00, 1'b0);

    // Reset with a word offered: nothing may be accepted.
    step();
    step();
    o = outs(0);
    chk("rst_tx",    {31'd0, o[3]}, 32'd1);
    chk("rst_busy",  {31'd0, o[2]}, 32'd0);
    chk("rst_done",  {31'd0, o[1]}, 32'd0);
    chk("rst_ready", {31'd0, o[0]}, 32'd1);
    drive(0, 8'h00, 1'b0);
    reset = 1'b1;
    step();
    o = outs(0);
    chk("rst_noaccept_busy", {31'd0, o[2]}, 32'd0);
    chk("rst_noaccept_tx",   {31'd0, o[3]}, 32'd1);

    // 0xA5, parity 0, with input noise while busy.
    send(0, 8'hA5);
    check_frame(0, "a5", {1'b1, 1'b0, 8'hA5, 1'b0}, 11, 4, 1'b1);
    after_done(0, "a5");

    // 0x07 -> parity 1; 0x00 -> parity 0.
    send(0, 8'h07);
    check_frame(0, "h07", {1'b1, 1'b1, 8'h07, 1'b0}, 11, 4, 1'b0);
    after_done(0, "h07");
    send(0, 8'h00);
    check_frame(0, "h00", {1'b1, 1'b0, 8'h00, 1'b0}, 11, 4, 1'b0);
    after_done(0, "h00");

    // Back-to-back with in_valid held: second word taken on the done cycle.
    drive(0, 8'h01, 1'b1);
    step();
    drive(0, 8'h80, 1'b1);
    check_frame(0, "b2b1", {1'b1, 1'b1, 8'h01, 1'b0}, 11, 4, 1'b0);
    step();
    drive(0, 8'h00, 1'b0);
    check_frame(0, "b2b2", {1'b1, 1'b1, 8'h80, 1'b0}, 11, 4, 1'b0);
    after_done(0, "b2b2");

    // Reset at cycle 10 of a frame (data bit 1 of 0x3C is on the line).
    send(0, 8'h3C);
    for (int i = 0; i < 9; i++) step();
    o = outs(0);
    chk("abort_pre_tx",   {31'd0, o[3]}, 32'd0);
    chk("abort_pre_busy", {31'd0, o[2]}, 32'd1);
    reset = 1'b0;
    step();
    reset = 1'b1;
    o = outs(0);
    chk("abort_tx",    {31'd0, o[3]}, 32'd1);
    chk("abort_busy",  {31'd0, o[2]}, 32'd0);
    chk("abort_ready", {31'd0, o[0]}, 32'd1);
    chk("abort_done",  {31'd0, o[1]}, 32'd0);
    for (int i = 0; i < 50; i++) begin
      step();
      o = outs(0);
      chk("abort_nodone", {31'd0, o[1]}, 32'd0);
      chk("abort_idle",   {31'd0, o[3]}, 32'd1);
    end
    send(0, 8'h5A);
    check_frame(0, "h5a", {1'b1, 1'b0, 8'h5A, 1'b0}, 11, 4, 1'b0);
    after_done(0, "h5a");

    // No-parity build: 10 bits, 40 cycles.
    send(1, 8'hA5);
    check_frame(1, "nopar", {6'd0, 1'b1, 8'hA5, 1'b0}, 10, 4, 1'b0);
    after_done(1, "nopar");

    // 1-bit, 2 clocks/bit: tx 0,0,1,1,1,1,1,1, done at cycle 9.
    send(2, 8'h01);
    check_frame(2, "w1", 16'b0000_0000_0000_1110, 4, 2, 1'b0);
    after_done(2, "w1");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
